// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle of the multicycle MIPS core: instruction fields and ALU flag in,
// datapath steering and write strobes out.
interface mips_multicycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       PC_Enable;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp;
  logic [3:0] ALUControl;
  logic [1:0] PCSrc;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero,
    output PC_Enable, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ExtOp, ALUControl, PCSrc, Illegal, State
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  PC_Enable, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ExtOp, ALUControl, PCSrc, Illegal, State
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core: steps each instruction through
// fetch/decode/execute/memory/writeback and steers the shared datapath.
module mips_multicycle_control (
  input  logic                       clk,
  input  logic                       reset,
  mips_multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // {valid, alu_control} for an R-type ALU funct; jr is handled separately.
  function automatic logic [4:0] r_funct_decode(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return {1'b1, ALU_ADD};
      FN_SUB:  return {1'b1, ALU_SUB};
      FN_AND:  return {1'b1, ALU_AND};
      FN_OR:   return {1'b1, ALU_OR};
      FN_NOR:  return {1'b1, ALU_NOR};
      FN_SLT:  return {1'b1, ALU_SLT};
      default: return {1'b0, ALU_AND};
    endcase
  endfunction

  // {ext_op, alu_control} for the immediate ALU group; logical ops zero-extend.
  function automatic logic [4:0] imm_op_decode(input logic [5:0] op);
    case (op)
      OP_SLTI: return {1'b0, ALU_SLT};
      OP_ANDI: return {1'b1, ALU_AND};
      OP_ORI:  return {1'b1, ALU_OR};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

  state_t     state_q, state_d;

  logic       pc_enable;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_op;
  logic [3:0] alu_control;
  logic [1:0] pc_src;
  logic       illegal;
  logic [4:0] r_dec;
  logic [4:0] imm_dec;

  assign r_dec   = r_funct_decode(bus.Funct);
  assign imm_dec = imm_op_decode(bus.Opcode);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_enable   = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    ext_op      = 1'b0;
    alu_control = ALU_AND;
    pc_src      = 2'd0;
    illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write    = 1'b1;
        alu_src_b   = 2'd1;
        alu_control = ALU_ADD;
        pc_enable   = 1'b1;
        state_d     = S_DECODE;
      end
      // Branch target is precomputed here so BRANCH can load it from ALUOut.
      S_DECODE: begin
        alu_src_b   = 2'd3;
        alu_control = ALU_ADD;
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE: begin
            if (bus.Funct == FN_JR) state_d = S_JR;
            else if (r_dec[4])      state_d = S_R_EXEC;
            else                    illegal = 1'b1;
          end
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_J:                               state_d = S_JUMP;
          OP_JAL:                             state_d = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IMM_EXEC;
          default:                            illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        alu_control = ALU_ADD;
        state_d     = (bus.Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        iord    = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg = 2'd1;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = r_dec[3:0];
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_dst   = 2'd1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'd1;
        pc_enable   = (bus.Opcode == OP_BNE) ? ~bus.Zero : bus.Zero;
      end
      S_JUMP: begin
        pc_src    = 2'd2;
        pc_enable = 1'b1;
      end
      S_IMM_EXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        ext_op      = imm_dec[4];
        alu_control = imm_dec[3:0];
        state_d     = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
      end
      // Pre-edge PC already holds PC+4, so it is the link value written to $31.
      S_JAL: begin
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        reg_write  = 1'b1;
        pc_src     = 2'd2;
        pc_enable  = 1'b1;
      end
      S_JR: begin
        pc_src    = 2'd3;
        pc_enable = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every strobe combinationally so a mid-instruction reset cannot write.
  always_comb begin
    bus.PC_Enable  = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 2'd0;
    bus.MemtoReg   = 2'd0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'd0;
    bus.ExtOp      = 1'b0;
    bus.ALUControl = 4'd0;
    bus.PCSrc      = 2'd0;
    bus.Illegal    = 1'b0;
    bus.State      = 4'd0;
    if (!reset) begin
      bus.PC_Enable  = pc_enable;
      bus.IorD       = iord;
      bus.MemWrite   = mem_write;
      bus.IRWrite    = ir_write;
      bus.RegDst     = reg_dst;
      bus.MemtoReg   = mem_to_reg;
      bus.RegWrite   = reg_write;
      bus.ALUSrcA    = alu_src_a;
      bus.ALUSrcB    = alu_src_b;
      bus.ExtOp      = ext_op;
      bus.ALUControl = alu_control;
      bus.PCSrc      = pc_src;
      bus.Illegal    = illegal;
      bus.State      = state_q;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for mips_multicycle_control against an instruction-level reference model.
module tb_mips_multicycle_control;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_multicycle_control_if bus();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_JR = 3, C_BEQ = 4, C_BNE = 5,
                 C_J = 6, C_JAL = 7, C_IMM = 8, C_ILL = 9;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] observed();
    return {bus.PC_Enable, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
            bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.ALUControl, bus.PCSrc,
            bus.Illegal, bus.State};
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: begin
        if (fn == 6'b001000) return C_JR;
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010})
          return C_R;
        return C_ILL;
      end
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      6'b001000, 6'b001010, 6'b001100, 6'b001101: return C_IMM;
      default: return C_ILL;
    endcase
  endfunction

  // Sequence of named steps each instruction class walks through, as state numbers.
  function automatic void build_path(input int cls, output int p[$]);
    p = {0, 1};
    case (cls)
      C_LW:  p = {p, 2, 3, 4};
      C_SW:  p = {p, 2, 5};
      C_R:   p = {p, 6, 7};
      C_JR:  p = {p, 13};
      C_BEQ, C_BNE: p = {p, 8};
      C_J:   p = {p, 9};
      C_JAL: p = {p, 12};
      C_IMM: p = {p, 10, 11};
      default: ;
    endcase
  endfunction

  function automatic int cpi_of(input int cls);
    case (cls)
      C_LW: return 5;
      C_SW, C_R, C_IMM: return 4;
      C_ILL: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      default:   return 4'b0111;
    endcase
  endfunction

  function automatic logic [23:0] exp_vec(input int st, input int cls, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z);
    logic pce = 0, iord = 0, mw = 0, irw = 0, rw = 0, asa = 0, ext = 0, ill = 0;
    logic [1:0] rd = 0, m2r = 0, asb = 0, pcs = 0;
    logic [3:0] alu = 0;
    logic [3:0] s4 = st[3:0];
    case (st)
      0:  begin irw = 1; asb = 1; alu = 4'b0010; pce = 1; end
      1:  begin asb = 3; alu = 4'b0010; ill = (cls == C_ILL); end
      2:  begin asa = 1; asb = 2; alu = 4'b0010; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; alu = r_alu(fn); end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; alu = 4'b0110; pcs = 1; pce = (cls == C_BEQ) ? z : !z; end
      9:  begin pcs = 2; pce = 1; end
      10: begin
        asa = 1; asb = 2;
        if (op == 6'b001010)      alu = 4'b0111;
        else if (op == 6'b001100) begin alu = 4'b0000; ext = 1; end
        else if (op == 6'b001101) begin alu = 4'b0001; ext = 1; end
        else                      alu = 4'b0010;
      end
      11: rw = 1;
      12: begin rd = 2; m2r = 2; rw = 1; pcs = 2; pce = 1; end
      13: begin pcs = 3; pce = 1; end
      default: ;
    endcase
    return {pce, iord, mw, irw, rd, m2r, rw, asa, asb, ext, alu, pcs, ill, s4};
  endfunction

  // zmode: 0/1 holds Zero at that value, 2 randomizes it every cycle.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int zmode);
    int p[$];
    int cls;
    int irw_cnt, pce_cnt, exp_pce, dut_cpi;
    logic z;
    cls = classify(op, fn);
    build_path(cls, p);
    irw_cnt = 0; pce_cnt = 0; exp_pce = 1; dut_cpi = 0;
    bus.Opcode = op;
    bus.Funct  = fn;
    for (int i = 0; i < p.size(); i++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      bus.Zero = z;
      #1;
      check_eq({name, "_outs"}, 32'(observed()), 32'(exp_vec(p[i], cls, op, fn, z)));
      irw_cnt += int'(bus.IRWrite);
      pce_cnt += int'(bus.PC_Enable);
      if (p[i] == 8 && ((cls == C_BEQ && z) || (cls == C_BNE && !z))) exp_pce++;
      if (p[i] inside {9, 12, 13}) exp_pce++;
      @(posedge clk);
      #1;
      if (bus.State == 4'd0 && dut_cpi == 0) dut_cpi = i + 1;
    end
    check_eq({name, "_cpi"}, 32'(dut_cpi), 32'(cpi_of(cls)));
    check_eq({name, "_irwrite_cnt"}, 32'(irw_cnt), 32'd1);
    check_eq({name, "_pcen_cnt"}, 32'(pce_cnt), 32'(exp_pce));
  endtask

  initial begin
    logic [5:0] op, fn;
    logic [5:0] valid_fn [7];
    logic [5:0] ops [10];
    checks = 0;
    errors = 0;
    valid_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b001000};
    ops = '{6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011,
            6'b001000, 6'b001010, 6'b001100, 6'b001101};
    reset = 1'b1;
    bus.Opcode = 6'b100011;
    bus.Funct  = 6'd0;
    bus.Zero   = 1'b0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("reset_outs", 32'(observed()), 32'd0);
    end
    reset = 1'b0;

    run_instr("lw",     6'b100011, 6'd0,      2);
    run_instr("sw",     6'b101011, 6'd0,      2);
    run_instr("slt",    6'b000000, 6'b101010, 2);
    run_instr("beq_t",  6'b000100, 6'd0,      1);
    run_instr("beq_nt", 6'b000100, 6'd0,      0);
    run_instr("bne_t",  6'b000101, 6'd0,      0);
    run_instr("bne_nt", 6'b000101, 6'd0,      1);
    run_instr("j",      6'b000010, 6'd0,      2);
    run_instr("jal",    6'b000011, 6'd0,      2);
    run_instr("jr",     6'b000000, 6'b001000, 2);
    run_instr("ill",    6'b111111, 6'd0,      2);
    run_instr("ill_fn", 6'b000000, 6'b000001, 2);
    run_instr("ori",    6'b001101, 6'd0,      2);

    // Reset while the store strobe would be active.
    bus.Opcode = 6'b101011;
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    check_eq("sw_in_memwrite", 32'(bus.State), 32'd5);
    check_eq("sw_memwrite_hi", 32'(bus.MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("reset_in_memwrite", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("after_reset_fetch", 32'(observed()), 32'(exp_vec(0, C_SW, 6'b101011, 6'd0, 1'b0)));

    // Reset while an illegal opcode sits in DECODE.
    bus.Opcode = 6'b111111;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("reset_in_decode", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          op = 6'b000000;
          fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : valid_fn[$urandom_range(0, 6)];
        end
        1: begin op = 6'($urandom); fn = 6'($urandom); end
        default: begin op = ops[$urandom_range(0, 9)]; fn = 6'($urandom); end
      endcase
      run_instr("rand", op, fn, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control FSM of the multicycle MIPS core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the PC register enable, the instruction/data memory controls, the IR load and the register-file writes. It also drives the ALU operand and operation selects for the shared datapath (PC register, IR/MDR, A/B, ALUOut, single memory). Outputs are a Moore decode of the current state, plus opcode/funct/Zero in the states that need them.

## Interface
- No parameters; all widths are fixed by the MIPS ISA.
- clk  in  1  rising-edge clock for the whole core
- reset  in  1  synchronous, active-high; forces state FETCH and all outputs 0
- Opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, same cycle
- PC_Enable  out  1  PC register load enable
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  IR load enable
- RegDst  out  2  write register: 0 = rt, 1 = rd, 2 = $31
- MemtoReg  out  2  write data: 0 = ALUOut, 1 = MDR, 2 = PC
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  0 = B, 1 = 4, 2 = ExtImm, 3 = SignImm<<2
- ExtOp  out  1  immediate extension: 0 = sign, 1 = zero
- ALUControl  out  4  ALU operation: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100
- PCSrc  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], IR[25:0], 2'b00}, 3 = A
- Illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode or funct
- State  out  4  current state encoding, for debug

## Operation
- Any output not listed for a state is 0.
- State encodings are 0..13, in this order:
  - FETCH: IRWrite=1, ALUSrcB=1, ADD, PCSrc=0, PC_Enable=1.
  - DECODE: ALUSrcB=3, ADD (computes the branch target into ALUOut). Next state by opcode:
    - lw/sw → MEM_ADDR
    - R-type: funct jr → JR; other valid funct → R_EXEC
    - beq/bne → BRANCH
    - j → JUMP
    - jal → JAL
    - addi/andi/ori/slti → IMM_EXEC
    - anything else → Illegal=1, next FETCH
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD. Next MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: IorD=1. Next MEM_WB.
  - MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
  - MEM_WRITE: IorD=1, MemWrite=1. Next FETCH.
  - R_EXEC: ALUSrcA=1, ALUSrcB=0. ALUControl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT. Next ALU_WB.
  - ALU_WB: RegDst=1, RegWrite=1. Next FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCSrc=1. PC_Enable = Zero for beq, ~Zero for bne. Next FETCH.
  - JUMP: PCSrc=2, PC_Enable=1. Next FETCH.
  - IMM_EXEC: ALUSrcA=1, ALUSrcB=2.
    - addi → ADD, ExtOp=0
    - slti → SLT, ExtOp=0
    - andi → AND, ExtOp=1
    - ori → OR, ExtOp=1
    - Next IMM_WB.
  - IMM_WB: RegDst=0, RegWrite=1. Next FETCH.
  - JAL: RegDst=2, MemtoReg=2, RegWrite=1, PCSrc=2, PC_Enable=1. The $31 write and the PC load happen on the same edge; the write data is the pre-edge PC, which is already PC+4. Next FETCH.
  - JR: PCSrc=3, PC_Enable=1. Next FETCH.
- Unused encodings 14–15: all outputs 0, next FETCH.
- This block does not hold the PC value. The PC register resets itself to 0x00400000 concurrently.

## Timing
- State register and any registered flags update on the rising edge of clk only.
- During every cycle reset is high: all outputs 0 and State = 0. This applies mid-instruction too: no memory write, register write or PC load occurs in the reset cycle.
- The first cycle with reset low is FETCH.
- Cycles per instruction, FETCH through last state:
  - lw 5
  - sw, R-type, immediate ALU 4
  - beq, bne, j, jal, jr 3
  - illegal 2
- Exactly one IRWrite pulse per instruction, always in FETCH.
- PC_Enable pulses at most twice per instruction: FETCH, plus one of BRANCH (taken), JUMP, JAL or JR.
- Outputs are combinational from the state register and inputs, with no extra latency. Opcode/Funct must not change between DECODE and the end of the instruction.
- Zero is sampled only in BRANCH.

## Test plan
- Reset:
  - Hold reset for 2 cycles → all outputs 0.
  - Release → State=0, IRWrite=1, PC_Enable=1 on the first edge.
  - Assert reset in MEM_WRITE → MemWrite=0 that cycle, FETCH next.
- lw (Opcode 100011):
  - State sequence 0,1,2,3,4,0.
  - MEM_READ IorD=1; MEM_WB RegWrite=1, MemtoReg=1, RegDst=0.
- sw (Opcode 101011): State 0,1,2,5,0, with MemWrite=1 only in state 5.
- R-type, funct 101010 (SLT): R_EXEC ALUControl=0111; ALU_WB RegDst=1, RegWrite=1; 4 cycles total.
- Branches:
  - beq with Zero=1 → PC_Enable=1, PCSrc=1 in BRANCH.
  - beq with Zero=0 → PC_Enable=0.
  - bne with Zero=0 → PC_Enable=1.
- Jumps and illegal:
  - jal → RegDst=2, MemtoReg=2, RegWrite=1, PC_Enable=1, PCSrc=2 in one cycle.
  - jr (funct 001000) → PCSrc=3, PC_Enable=1.
  - Opcode 111111 → Illegal=1 in DECODE, FETCH next.
